// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared widths, FSM encoding and step amounts for the fp16 datapath
package fp16_pkg;

  localparam int MANT_W  = 11;
  localparam int EXP_W   = 5;
  localparam int SHIFT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } norm_state_t;

  localparam logic [SHIFT_W-1:0] K_STEP0 = 4'd8;
  localparam logic [SHIFT_W-1:0] K_STEP1 = 4'd4;
  localparam logic [SHIFT_W-1:0] K_STEP2 = 4'd2;
  localparam logic [SHIFT_W-1:0] K_STEP3 = 4'd1;

  function automatic logic [SHIFT_W-1:0] step_k(input logic [1:0] idx);
    case (idx)
      2'd0:    step_k = K_STEP0;
      2'd1:    step_k = K_STEP1;
      2'd2:    step_k = K_STEP2;
      default: step_k = K_STEP3;
    endcase
  endfunction

endpackage

// File: rtl/mantissa_normalizer_left_lshift_stage.sv
// rtl/mantissa_normalizer_left_lshift_stage.sv - one conditional left-shift-by-k step
module lshift_stage #(
  parameter int MANT_W  = 11,
  parameter int EXP_W   = 5,
  parameter int SHIFT_W = 4
) (
  input  logic [MANT_W-1:0]  mant_in,
  input  logic [EXP_W-1:0]   exp_in,
  input  logic [SHIFT_W-1:0] k,
  output logic [MANT_W-1:0]  mant_out,
  output logic [EXP_W-1:0]   exp_out,
  output logic               taken
);

  logic               top_zero;
  logic [MANT_W-1:0]  mant_sh;
  logic [EXP_W-1:0]   exp_dec;

  always_comb begin
    top_zero = 1'b1;
    for (int i = 0; i < MANT_W; i++) begin
      if ((i >= MANT_W - int'(k)) && mant_in[i]) top_zero = 1'b0;
    end
  end

  assign mant_sh = mant_in << k;
  assign exp_dec = exp_in - EXP_W'(k);
  // The exponent guard keeps the result denormal instead of wrapping below zero.
  assign taken   = top_zero && (exp_in >= EXP_W'(k));

  for (genvar b = 0; b < MANT_W; b++) begin : g_mant_mux
    mux_2to1 u_mux (.d0(mant_in[b]), .d1(mant_sh[b]), .sel(taken), .y(mant_out[b]));
  end

  for (genvar b = 0; b < EXP_W; b++) begin : g_exp_mux
    mux_2to1 u_mux (.d0(exp_in[b]), .d1(exp_dec[b]), .sel(taken), .y(exp_out[b]));
  end

endmodule

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - single-bit 2:1 mux cell
module mux_2to1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mantissa_normalizer_left.sv
// rtl/mantissa_normalizer_left.sv - multi-cycle left normaliser with exponent-limited shift
module mantissa_normalizer_left import fp16_pkg::*; #(
  parameter int MANT_W  = fp16_pkg::MANT_W,
  parameter int EXP_W   = fp16_pkg::EXP_W,
  parameter int SHIFT_W = fp16_pkg::SHIFT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic [EXP_W-1:0]   in_exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  out_mant,
  output logic [EXP_W-1:0]   out_exp,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_zero
);

  norm_state_t        state;
  logic [1:0]         step;
  logic [MANT_W-1:0]  mant_r;
  logic [EXP_W-1:0]   exp_r;
  logic [SHIFT_W-1:0] acc;
  logic               zero_r;

  logic [SHIFT_W-1:0] k;
  logic [MANT_W-1:0]  st_mant;
  logic [EXP_W-1:0]   st_exp;
  logic               st_taken;
  logic               do_shift;
  logic [MANT_W-1:0]  nxt_mant;
  logic [EXP_W-1:0]   nxt_exp;
  logic [SHIFT_W-1:0] nxt_acc;

  assign k = SHIFT_W'(step_k(step));

  lshift_stage #(.MANT_W(MANT_W), .EXP_W(EXP_W), .SHIFT_W(SHIFT_W)) u_stage (
    .mant_in (mant_r),
    .exp_in  (exp_r),
    .k       (k),
    .mant_out(st_mant),
    .exp_out (st_exp),
    .taken   (st_taken)
  );

  // A zero mantissa still walks all four steps so latency stays constant.
  always_comb begin
    do_shift = st_taken && !zero_r;
    nxt_mant = do_shift ? st_mant : mant_r;
    nxt_exp  = do_shift ? st_exp : exp_r;
    nxt_acc  = do_shift ? acc + k : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      step      <= 2'd0;
      mant_r    <= '0;
      exp_r     <= '0;
      acc       <= '0;
      zero_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            mant_r   <= in_mant;
            exp_r    <= in_exp;
            acc      <= '0;
            zero_r   <= (in_mant == '0);
            step     <= 2'd0;
            in_ready <= 1'b0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          mant_r <= nxt_mant;
          exp_r  <= nxt_exp;
          acc    <= nxt_acc;
          if (step == 2'd3) begin
            out_mant  <= nxt_mant;
            out_exp   <= zero_r ? '0 : nxt_exp;
            out_shift <= nxt_acc;
            out_zero  <= zero_r;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_normalizer_left.sv
// tb/tb_mantissa_normalizer_left.sv - self-checking bench for mantissa_normalizer_left
module tb_mantissa_normalizer_left;

  typedef struct packed {
    logic [10:0] mant;
    logic [4:0]  exp;
    logic [3:0]  shift;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_mant;
  logic [4:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_mant;
  logic [4:0]  out_exp;
  logic [3:0]  out_shift;
  logic        out_zero;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  mantissa_normalizer_left dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_exp(out_exp), .out_shift(out_shift), .out_zero(out_zero)
  );

  function automatic res_t model(input logic [10:0] m, input logic [4:0] e);
    res_t r;
    int lz, sh;
    r = '0;
    if (m == 11'd0) begin
      r.zero = 1'b1;
    end else begin
      lz = 11;
      for (int i = 0; i < 11; i++) if (m[i]) lz = 10 - i;
      sh = (lz < int'(e)) ? lz : int'(e);
      r.mant  = m << sh;
      r.exp   = e - 5'(sh);
      r.shift = 4'(sh);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every cycle a result is presented it must match the model's oldest entry.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("sb_mant",  32'(out_mant),  32'(exp_q[0].mant));
        check("sb_exp",   32'(out_exp),   32'(exp_q[0].exp));
        check("sb_shift", 32'(out_shift), 32'(exp_q[0].shift));
        check("sb_zero",  32'(out_zero),  32'(exp_q[0].zero));
        check("sb_in_ready_busy", 32'(in_ready), 32'd0);
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  task automatic send(input logic [10:0] m, input logic [4:0] e);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_mant  = m;
    in_exp   = e;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(m, e));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'd4);
  endtask

  task automatic run_vec(input logic [10:0] m, input logic [4:0] e, input logic [10:0] rm,
                         input logic [4:0] re, input logic [3:0] rs, input logic rz);
    int lat;
    out_ready = 1'b1;
    send(m, e);
    wait_result(lat);
    check("lit_mant",  32'(out_mant),  32'(rm));
    check("lit_exp",   32'(out_exp),   32'(re));
    check("lit_shift", 32'(out_shift), 32'(rs));
    check("lit_zero",  32'(out_zero),  32'(rz));
    @(negedge clk);
    check("idle_in_ready",  32'(in_ready),  32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    #1;
  endtask

  initial begin
    int lat;
    reset = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_mant",  32'(out_mant),  32'd0);
    check("rst_out_exp",   32'(out_exp),   32'd0);
    check("rst_out_shift", 32'(out_shift), 32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    #1;

    run_vec(11'h001, 5'd20, 11'h400, 5'd10, 4'd10, 1'b0);
    run_vec(11'h5A3, 5'd15, 11'h5A3, 5'd15, 4'd0,  1'b0);
    run_vec(11'h010, 5'd3,  11'h080, 5'd0,  4'd3,  1'b0);
    run_vec(11'h000, 5'd17, 11'h000, 5'd0,  4'd0,  1'b1);
    run_vec(11'h0FF, 5'd0,  11'h0FF, 5'd0,  4'd0,  1'b0);
    run_vec(11'h001, 5'd11, 11'h400, 5'd1,  4'd10, 1'b0);
    run_vec(11'h020, 5'd5,  11'h400, 5'd0,  4'd5,  1'b0);
    run_vec(11'h001, 5'd31, 11'h400, 5'd21, 4'd10, 1'b0);
    run_vec(11'h07F, 5'd2,  11'h1FC, 5'd0,  4'd2,  1'b0);

    // Backpressure: result must hold for five cycles with out_ready low.
    out_ready = 1'b0;
    send(11'h003, 5'd30);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_mant",     32'(out_mant),  32'h600);
      check("bp_exp",      32'(out_exp),   32'd21);
      check("bp_shift",    32'(out_shift), 32'd9);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    #1;

    // Reset during the second SHIFT cycle discards the in-flight result.
    send(11'h001, 5'd20);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_mant",  32'(out_mant),  32'd0);
    check("midrst_out_exp",   32'(out_exp),   32'd0);
    check("midrst_out_shift", 32'(out_shift), 32'd0);
    check("midrst_out_zero",  32'(out_zero),  32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) check("midrst_no_pulse", 32'(out_valid), 32'd0);
    end
    #1;
    run_vec(11'h001, 5'd20, 11'h400, 5'd10, 4'd10, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
